// File: rtl/pezaris_mult_seq_if.sv
// Operand/product handshake bundle for pezaris_mult_seq.
//
// Handshake rules (both channels): a transfer happens on the rising clk edge
// where valid and ready are both high. The sender holds valid and its data
// stable until that edge. The receiver may raise or lower ready freely, and
// ready never depends combinationally on valid.
interface pezaris_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    // Operand source and product sink side.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    // Multiplier side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/pezaris_mult_seq.sv
// Sequential two's-complement multiplier. Each ACCUM cycle retires one
// partial-product row into a carry-save accumulator and shifts one finished
// low product bit out. RESOLVE then adds sum and carry into the high half.
// Negative-weight partial-product bits are complemented, and the correction
// constants 2^WIDTH and 2^(2*WIDTH-1) are injected into the free top sum bit,
// so the result is exact modulo 2^(2*WIDTH).
module pezaris_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    pezaris_mult_seq_if.slave   bus,
    output logic [1:0]          state_dbg
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     b_q;
    logic [WIDTH-1:0]     sum_q;
    logic [WIDTH-1:0]     carry_q;
    logic [WIDTH-1:0]     lo_q;
    logic [CW-1:0]        row_q;
    logic [2*WIDTH-1:0]   product_q;

    logic                 last_row;
    logic                 inject;
    logic [WIDTH-1:0]     pp;
    logic [WIDTH-1:0]     fa_sum;
    logic [WIDTH-1:0]     fa_carry;

    // One row of full-adder cells. Bit a[W-1] in ordinary rows and bits
    // i<W-1 in the multiplier-sign row carry negative weight, so they enter
    // complemented. Cell (W-1, W-1) is positive and enters unchanged.
    always_comb begin
        last_row = (row_q == CW'(WIDTH - 1));
        inject   = (row_q == '0) || last_row;
        pp       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pp[i] = (a_q[i] & b_q[row_q]) ^ ((i == WIDTH - 1) ^ last_row);
        end
        fa_sum   = sum_q ^ carry_q ^ pp;
        fa_carry = (sum_q & carry_q) | (sum_q & pp) | (carry_q & pp);
    end

    // Next-state logic; outputs are decoded from the state register below.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = ACCUM;
            ACCUM:   if (last_row)      state_next = RESOLVE;
            RESOLVE:                    state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default:                    state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Operand capture, carry-save accumulation and final resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            lo_q      <= '0;
            row_q     <= '0;
            product_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        sum_q   <= '0;
                        carry_q <= '0;
                        lo_q    <= '0;
                        row_q   <= '0;
                    end
                end
                ACCUM: begin
                    // After the shift the top sum bit is free; after row 0 it
                    // weighs 2^W, after the last row 2^(2W-1).
                    sum_q   <= {inject, fa_sum[WIDTH-1:1]};
                    carry_q <= fa_carry;
                    lo_q    <= {fa_sum[0], lo_q[WIDTH-1:1]};
                    row_q   <= row_q + 1'b1;
                end
                RESOLVE: begin
                    product_q <= {sum_q + carry_q, lo_q};
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state == ACCUM) || (state == RESOLVE);
    assign bus.product   = product_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_pezaris_mult_seq.sv
// Bench for pezaris_mult_seq: directed WIDTH=8 cases, an exhaustive WIDTH=4
// sweep and random WIDTH=16 traffic, all checked against a reference product
// queued when the operands are handed over.
module tb_pezaris_mult_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pezaris_mult_seq_if #(.WIDTH(8))  m8  ();
    pezaris_mult_seq_if #(.WIDTH(4))  m4  ();
    pezaris_mult_seq_if #(.WIDTH(16)) m16 ();
    logic [1:0] st8, st4, st16;

    pezaris_mult_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(m8),  .state_dbg(st8));
    pezaris_mult_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(m4),  .state_dbg(st4));
    pezaris_mult_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(m16), .state_dbg(st16));

    logic [15:0] exp8_q[$];
    logic [7:0]  exp4_q[$];
    logic [31:0] exp16_q[$];

    int errors;
    int checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 transaction; out_ready stays low for 'hold' cycles of DONE.
    task automatic op8(input logic [7:0] x, input logic [7:0] y, input int hold);
        int n;
        logic [15:0] held;
        bit stable;
        n = 0;
        while (!m8.in_ready && n < 100) begin @(negedge clk); n++; end
        check("op8_in_ready", 32'(m8.in_ready), 32'd1);
        m8.a = x; m8.b = y; m8.in_valid = 1'b1; m8.out_ready = 1'b0;
        exp8_q.push_back(16'(int'($signed(x)) * int'($signed(y))));
        @(negedge clk);
        m8.in_valid = 1'b0;
        m8.a = ~x; m8.b = ~y;
        n = 1;
        while (!m8.out_valid && n < 100) begin @(negedge clk); n++; end
        check("op8_latency", n, 10);
        held = m8.product; stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!m8.out_valid || m8.product !== held || m8.in_ready) stable = 1'b0;
        end
        if (hold > 0) check("op8_hold_stable", 32'(stable), 32'd1);
        check("op8_product", 32'(m8.product), 32'(exp8_q.pop_front()));
        m8.out_ready = 1'b1;
        @(negedge clk);
        m8.out_ready = 1'b0;
        check("op8_out_valid_drop", 32'(m8.out_valid), 32'd0);
        check("op8_in_ready_back", 32'(m8.in_ready), 32'd1);
    endtask

    int n, sent, recv, cyc;
    bit stable;
    logic [3:0] x4, y4;
    logic [15:0] x16, y16;

    initial begin
        errors = 0; checks = 0;
        m8.in_valid = 0;  m8.a = '0;  m8.b = '0;  m8.out_ready = 0;
        m4.in_valid = 0;  m4.a = '0;  m4.b = '0;  m4.out_ready = 0;
        m16.in_valid = 0; m16.a = '0; m16.b = '0; m16.out_ready = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready",  32'(m8.in_ready),  32'd1);
        check("rst_out_valid", 32'(m8.out_valid), 32'd0);
        check("rst_busy",      32'(m8.busy),      32'd0);
        check("rst_product",   32'(m8.product),   32'd0);
        check("rst_state",     32'(st8),          32'd0);

        // Directed WIDTH=8 products, then a long output stall.
        op8(8'd5,   8'hFD, 0);
        op8(8'h80,  8'h80, 0);
        op8(8'h80,  8'h7F, 0);
        op8(8'h00,  8'hFF, 0);
        op8(8'h7F,  8'h7F, 0);
        op8(8'hC3,  8'h05, 20);

        // in_valid held high with changing operands while the block is busy.
        n = 0;
        while (!m8.in_ready && n < 100) begin @(negedge clk); n++; end
        m8.a = 8'd13; m8.b = 8'hFA; m8.in_valid = 1'b1; m8.out_ready = 1'b0;
        exp8_q.push_back(16'(13 * -6));
        @(negedge clk);
        n = 1; stable = 1'b1;
        while (!m8.out_valid && n < 100) begin
            if (m8.in_ready || !m8.busy) stable = 1'b0;
            m8.a = 8'($urandom_range(0, 255)); m8.b = 8'($urandom_range(0, 255));
            @(negedge clk); n++;
        end
        check("busy_in_ready_low", 32'(stable), 32'd1);
        check("busy_latency", n, 10);
        repeat (3) begin
            m8.a = 8'($urandom_range(0, 255));
            @(negedge clk);
            if (m8.in_ready || !m8.out_valid) stable = 1'b0;
        end
        check("done_in_ready_low", 32'(stable), 32'd1);
        check("busy_product", 32'(m8.product), 32'(exp8_q.pop_front()));
        m8.in_valid = 1'b0; m8.out_ready = 1'b1;
        @(negedge clk);
        m8.out_ready = 1'b0;
        check("busy_in_ready_back", 32'(m8.in_ready), 32'd1);

        // Reset during ACCUM row 3 aborts the operation.
        m8.a = 8'd9; m8.b = 8'd11; m8.in_valid = 1'b1;
        @(negedge clk);
        m8.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 32'(m8.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(m8.out_valid), 32'd0);
        check("abort_product",   32'(m8.product),   32'd0);
        check("abort_busy",      32'(m8.busy),      32'd0);
        check("abort_in_ready",  32'(m8.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        repeat (15) begin @(negedge clk); if (m8.out_valid) stable = 1'b0; end
        check("abort_no_spurious", 32'(stable), 32'd1);
        op8(8'd7, 8'd7, 0);

        // Exhaustive signed sweep at WIDTH=4.
        m4.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                n = 0;
                while (!m4.in_ready && n < 50) begin @(negedge clk); n++; end
                x4 = 4'(i); y4 = 4'(j);
                m4.a = x4; m4.b = y4; m4.in_valid = 1'b1;
                exp4_q.push_back(8'(int'($signed(x4)) * int'($signed(y4))));
                @(negedge clk);
                m4.in_valid = 1'b0;
                n = 1;
                while (!m4.out_valid && n < 50) begin @(negedge clk); n++; end
                check("w4_product", 32'(m4.product), 32'(exp4_q.pop_front()));
                @(negedge clk);
            end
        end
        m4.out_ready = 1'b0;

        // Random back-to-back WIDTH=16 traffic with random out_ready.
        sent = 0; recv = 0; cyc = 0;
        while (recv < 200 && cyc < 20000) begin
            m16.out_ready = ($urandom_range(0, 3) != 0);
            if (m16.out_valid && m16.out_ready) begin
                check("w16_q_nonempty", 32'(exp16_q.size() != 0), 32'd1);
                if (exp16_q.size() != 0)
                    check("w16_product", m16.product, exp16_q.pop_front());
                recv++;
            end
            case ($urandom_range(0, 5))
                0:       x16 = 16'h8000;
                1:       x16 = 16'h7FFF;
                default: x16 = 16'($urandom);
            endcase
            y16 = ($urandom_range(0, 5) == 0) ? 16'h8000 : 16'($urandom);
            m16.a = x16; m16.b = y16;
            m16.in_valid = (sent < 200) && ($urandom_range(0, 3) != 0);
            if (m16.in_valid && m16.in_ready) begin
                exp16_q.push_back(32'(int'($signed(x16)) * int'($signed(y16))));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        m16.in_valid = 1'b0; m16.out_ready = 1'b0;
        check("w16_recv_count", recv, 200);
        check("w16_sent_count", sent, 200);
        check("w16_q_empty", exp16_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
